// File: rtl/clk_pkg.sv
// Shared types and constants for the HH:MM:SS clock with set mode.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package clk_pkg;

    // Values match the externally visible mode encoding.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_SET_SEC = 2'd3
    } state_e;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam int         NUM_DIGITS = 6;

    // Field limits used by the BCD increment helpers.
    localparam logic [3:0] UNITS_MAX    = 4'd9;
    localparam logic [3:0] TENS60_MAX   = 4'd5;
    localparam logic [3:0] HR_T_MAX     = 4'd2;
    localparam logic [3:0] HR_U_MAX_TOP = 4'd3;

    typedef struct packed {
        logic [3:0] hr_t;
        logic [3:0] hr_u;
        logic [3:0] min_t;
        logic [3:0] min_u;
        logic [3:0] sec_t;
        logic [3:0] sec_u;
    } bcd_time_t;

    // {tens, units} modulo-60 BCD increment; 59 wraps to 00.
    function automatic logic [7:0] inc_sixty(input logic [7:0] tu);
        logic [3:0] t;
        logic [3:0] u;
        t = tu[7:4];
        u = tu[3:0];
        if (u != UNITS_MAX) begin
            u = u + 4'd1;
        end else begin
            u = 4'd0;
            t = (t == TENS60_MAX) ? 4'd0 : t + 4'd1;
        end
        return {t, u};
    endfunction

    // {tens, units} hours BCD increment; 23 wraps to 00.
    function automatic logic [7:0] inc_hours(input logic [7:0] tu);
        logic [7:0] r;
        if (tu == {HR_T_MAX, HR_U_MAX_TOP}) begin
            r = 8'h00;
        end else if (tu[3:0] == UNITS_MAX) begin
            r = {tu[7:4] + 4'd1, 4'd0};
        end else begin
            r = {tu[7:4], tu[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low 7-segment pattern (a..g, dp in bit0); 10..15 blank.
// Latency: combinational.
// Backpressure: none.
// Ports: bcd (4-bit digit in), seg (8-bit active-low segments out).
module seg7_decode
    import clk_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = 8'h03;
            4'd1:    seg = 8'h9F;
            4'd2:    seg = 8'h25;
            4'd3:    seg = 8'h0D;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h49;
            4'd6:    seg = 8'hC1;
            4'd7:    seg = 8'h1F;
            4'd8:    seg = 8'h01;
            4'd9:    seg = 8'h19;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/time_set_ctrl.sv
// 24h BCD clock with RUN/SET_HR/SET_MIN/SET_SEC modes and a 6-digit multiplexed display.
// Latency: mode/tick zero-cycle from state; an/ca registered one cycle after digit index.
// Backpressure: none; buttons are debounced levels sampled every cycle, one press per rising edge.
// Ports: clk, rst (sync, active-high), btn_mode, btn_inc in; an, ca (active-low), mode, tick out.
module time_set_ctrl
    import clk_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [7:0] an,
    output logic [7:0] ca,
    output logic [1:0] mode,
    output logic       tick
);

    localparam int PS_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(CLK_HZ - 1);
    localparam logic [PS_W-1:0] PS_HALF  = PS_W'(CLK_HZ / 2);
    localparam logic [SC_W-1:0] SC_LAST  = SC_W'(SCAN_DIV - 1);
    localparam logic [2:0]      IDX_LAST = 3'(NUM_DIGITS - 1);

    // ---------------- press detect ----------------
    // The *_blk flags capture a button that is already held while in reset,
    // so it does not register as a press once reset releases.
    logic mode_q, inc_q, mode_blk, inc_blk;
    logic mode_press, inc_press;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= 1'b0;
            inc_q    <= 1'b0;
            mode_blk <= btn_mode;
            inc_blk  <= btn_inc;
        end else begin
            mode_q   <= btn_mode;
            inc_q    <= btn_inc;
            mode_blk <= mode_blk & btn_mode;
            inc_blk  <= inc_blk & btn_inc;
        end
    end

    assign mode_press = btn_mode & ~mode_q & ~mode_blk;
    assign inc_press  = btn_inc & ~inc_q & ~inc_blk;

    // ---------------- FSM + timekeeping ----------------
    state_e    state_q, state_d;
    bcd_time_t tm_q, tm_d;
    logic [PS_W-1:0] ps_q;
    logic            ps_clr;

    assign tick = (ps_q == PS_LAST);
    assign mode = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            tm_q    <= '0;
            ps_q    <= '0;
        end else begin
            state_q <= state_d;
            tm_q    <= tm_d;
            ps_q    <= (ps_clr || tick) ? '0 : ps_q + PS_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        tm_d    = tm_q;
        ps_clr  = 1'b0;

        if (mode_press) begin
            case (state_q)
                ST_RUN:     state_d = ST_SET_HR;
                ST_SET_HR:  state_d = ST_SET_MIN;
                ST_SET_MIN: state_d = ST_SET_SEC;
                default: begin
                    // Leaving set mode restarts the second so the first tick is a full period away.
                    state_d = ST_RUN;
                    ps_clr  = 1'b1;
                end
            endcase
        end

        // A mode press in the same cycle swallows any inc press.
        case (state_q)
            ST_RUN: begin
                if (tick) begin
                    {tm_d.sec_t, tm_d.sec_u} = inc_sixty({tm_q.sec_t, tm_q.sec_u});
                    if ({tm_q.sec_t, tm_q.sec_u} == {TENS60_MAX, UNITS_MAX}) begin
                        {tm_d.min_t, tm_d.min_u} = inc_sixty({tm_q.min_t, tm_q.min_u});
                        if ({tm_q.min_t, tm_q.min_u} == {TENS60_MAX, UNITS_MAX}) begin
                            {tm_d.hr_t, tm_d.hr_u} = inc_hours({tm_q.hr_t, tm_q.hr_u});
                        end
                    end
                end
            end
            ST_SET_HR: begin
                if (inc_press && !mode_press)
                    {tm_d.hr_t, tm_d.hr_u} = inc_hours({tm_q.hr_t, tm_q.hr_u});
            end
            ST_SET_MIN: begin
                if (inc_press && !mode_press)
                    {tm_d.min_t, tm_d.min_u} = inc_sixty({tm_q.min_t, tm_q.min_u});
            end
            default: begin
                if (inc_press && !mode_press)
                    {tm_d.sec_t, tm_d.sec_u} = inc_sixty({tm_q.sec_t, tm_q.sec_u});
            end
        endcase
    end

    // ---------------- display scan ----------------
    logic [SC_W-1:0] sc_q;
    logic [2:0]      idx_q;
    logic [3:0]      digit;
    logic            blank;
    logic [7:0]      seg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sc_q  <= '0;
            idx_q <= 3'd0;
        end else if (sc_q == SC_LAST) begin
            sc_q  <= '0;
            idx_q <= (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end else begin
            sc_q  <= sc_q + SC_W'(1);
        end
    end

    always_comb begin
        digit = 4'hF;
        case (idx_q)
            3'd0:    digit = tm_q.sec_u;
            3'd1:    digit = tm_q.sec_t;
            3'd2:    digit = tm_q.min_u;
            3'd3:    digit = tm_q.min_t;
            3'd4:    digit = tm_q.hr_u;
            3'd5:    digit = tm_q.hr_t;
            default: digit = 4'hF;
        endcase

        // Selected field flashes off during the second half of each second.
        blank = 1'b0;
        if (ps_q >= PS_HALF) begin
            case (state_q)
                ST_SET_HR:  blank = (idx_q >= 3'd4);
                ST_SET_MIN: blank = (idx_q == 3'd2) || (idx_q == 3'd3);
                ST_SET_SEC: blank = (idx_q <= 3'd1);
                default:    blank = 1'b0;
            endcase
        end
    end

    seg7_decode u_seg7_decode (
        .bcd (digit),
        .seg (seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            an <= 8'hFF;
            ca <= SEG_BLANK;
        end else begin
            an <= ~(8'd1 << idx_q);
            ca <= blank ? SEG_BLANK : seg;
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: seconds-of-day reference model plus directed scenarios.
// Latency: n/a.
// Backpressure: n/a.
module tb_time_set_ctrl;

    localparam int CLK_HZ   = 10;
    localparam int SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [7:0] an;
    logic [7:0] ca;
    logic [1:0] mode;
    logic       tick;

    time_set_ctrl #(.CLK_HZ(CLK_HZ), .SCAN_DIV(SCAN_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .an       (an),
        .ca       (ca),
        .mode     (mode),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] seg_tab [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                 8'h49, 8'hC1, 8'h1F, 8'h01, 8'h19};
    int m_secs = 0;   // seconds since midnight
    int m_mode = 0;
    int m_ps = 0;
    int m_scan = 0;
    int m_idx = 0;
    logic [7:0] m_an = 8'hFF;
    logic [7:0] m_ca = 8'hFF;
    bit m_pm = 1'b0;
    bit m_pi = 1'b0;

    function automatic int digit_of(input int secs, input int idx);
        int h, mi, s, d;
        h  = secs / 3600;
        mi = (secs / 60) % 60;
        s  = secs % 60;
        case (idx)
            0: d = s % 10;
            1: d = s / 10;
            2: d = mi % 10;
            3: d = mi / 10;
            4: d = h % 10;
            default: d = h / 10;
        endcase
        return d;
    endfunction

    always @(posedge clk) begin
        bit pmode, pinc, blank;
        int h, mi, s;
        if (rst) begin
            m_secs = 0; m_mode = 0; m_ps = 0; m_scan = 0; m_idx = 0;
            m_an = 8'hFF; m_ca = 8'hFF;
        end else begin
            pmode = btn_mode && !m_pm;
            pinc  = btn_inc && !m_pi;
            // display shows what the pre-edge digit slot selects
            blank = (m_mode != 0) && (m_ps >= CLK_HZ / 2) && (m_idx / 2 == 3 - m_mode);
            m_an  = 8'hFF ^ (8'h01 << m_idx);
            m_ca  = blank ? 8'hFF : seg_tab[digit_of(m_secs, m_idx)];
            h  = m_secs / 3600;
            mi = (m_secs / 60) % 60;
            s  = m_secs % 60;
            if (m_mode == 0) begin
                if (m_ps == CLK_HZ - 1) m_secs = (m_secs + 1) % 86400;
            end else if (pinc && !pmode) begin
                if (m_mode == 1) h = (h + 1) % 24;
                if (m_mode == 2) mi = (mi + 1) % 60;
                if (m_mode == 3) s = (s + 1) % 60;
                m_secs = h * 3600 + mi * 60 + s;
            end
            m_ps = (m_mode == 3 && pmode) ? 0 : (m_ps + 1) % CLK_HZ;
            if (pmode) m_mode = (m_mode + 1) % 4;
            if (m_scan == SCAN_DIV - 1) begin
                m_scan = 0;
                m_idx  = (m_idx + 1) % 6;
            end else begin
                m_scan = m_scan + 1;
            end
        end
        m_pm = btn_mode;
        m_pi = btn_inc;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_an", an, m_an);
            chk("cyc_ca", ca, m_ca);
            chk("cyc_mode", mode, m_mode);
            chk("cyc_tick", tick, m_ps == CLK_HZ - 1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic press_mode();
        btn_mode = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_inc(input int n);
        repeat (n) begin
            btn_inc = 1'b1;
            @(negedge clk);
            btn_inc = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits for digit idx to be shown unblanked, then checks its segments.
    task automatic read_digit(input int idx, input string nm, input logic [7:0] exp);
        int budget;
        logic [7:0] want_an;
        want_an = 8'hFF ^ (8'h01 << idx);
        budget = 0;
        while (!(an == want_an && ca != 8'hFF) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: digit %0d never shown unblanked within 200 cycles", nm, idx);
        end else begin
            chk(nm, ca, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        logic [7:0] an_seq [6];
        int s0;
        an_seq = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF};

        // Reset state, then one tick after 10 cycles and the anode walk.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_an", an, 8'hFF);
        chk("rst_ca", ca, 8'hFF);
        chk("rst_mode", mode, 0);
        chk("rst_tick", tick, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("t1_an0", an, an_seq[0]);
        chk("t1_ca0", ca, 8'h03);
        for (int k = 1; k < 6; k++) begin
            repeat (4) @(negedge clk);
            chk("t1_an", an, an_seq[k]);
            if (k == 1) chk("t1_tick_before", tick, 0);
            if (k == 2) chk("t1_tick_at_10", tick, 1);
            if (k == 3) chk("t1_model_secs", m_secs, 1);
        end
        read_digit(0, "t1_sec_u_after_2_ticks", 8'h25);

        // Preload 23:59:59 through set mode, return to RUN, roll over.
        do_reset();
        press_mode();
        press_inc(23);
        press_mode();
        press_inc(59);
        press_mode();
        press_inc(59);
        chk("t2_model_preload", m_secs, 86399);
        chk("t2_mode_set_sec", mode, 3);
        press_mode();
        repeat (7) @(negedge clk);
        chk("t2_tick_not_yet", tick, 0);
        @(negedge clk);
        chk("t2_tick_full_period", tick, 1);
        @(negedge clk);
        chk("t2_rollover_secs", m_secs, 0);
        chk("t2_mode_run", mode, 0);
        for (int i = 1; i < 6; i++) read_digit(i, "t2_digit_zero", 8'h03);

        // SET_MIN with 61 presses: minutes 00 -> 01, nothing else moves.
        press_mode();
        press_mode();
        chk("t3_mode_set_min", mode, 2);
        s0 = m_secs;
        press_inc(61);
        chk("t3_minutes_delta", m_secs - s0, 60);
        read_digit(2, "t3_min_u", 8'h9F);
        read_digit(4, "t3_hr_u", 8'h03);

        // Back to RUN, then mode and inc together: mode wins.
        press_mode();
        press_mode();
        chk("t4_mode_run", mode, 0);
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        @(negedge clk);
        chk("t4_mode_set_hr", mode, 1);
        chk("t4_hours", m_secs / 3600, 0);

        // Hold inc for 50 cycles in SET_HR: one increment only.
        btn_inc = 1'b1;
        repeat (50) @(negedge clk);
        btn_inc = 1'b0;
        @(negedge clk);
        chk("t5_hours", m_secs / 3600, 1);
        read_digit(4, "t5_hr_u", 8'h9F);
        read_digit(5, "t5_hr_t", 8'h03);

        // Reset mid-SET_SEC at 12:34:56.
        do_reset();
        press_mode();
        press_inc(12);
        press_mode();
        press_inc(34);
        press_mode();
        press_inc(56);
        chk("t6_model_preload", m_secs, 45296);
        chk("t6_mode_set_sec", mode, 3);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_mode", mode, 0);
        chk("t6_an", an, 8'hFF);
        chk("t6_ca", ca, 8'hFF);
        chk("t6_secs", m_secs, 0);
        rst = 1'b0;

        // Mode button held across reset release is not a press.
        rst = 1'b1;
        btn_mode = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("t7_held_no_press", mode, 0);
        btn_mode = 1'b0;
        @(negedge clk);
        press_mode();
        chk("t7_fresh_press", mode, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, meaning clk cycles per 1 s tick.
REQ-002 Parameter SCAN_DIV, default 100_000, meaning clk cycles per display digit slot.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 btn_mode  in  1  debounced level, mode-advance button.
REQ-006 btn_inc  in  1  debounced level, field-increment button.
REQ-007 an  out  8  digit anodes, active-low, one-hot-low.
REQ-008 ca  out  8  segments, active-low, bit7..bit0 = a,b,c,d,e,f,g,dp.
REQ-009 mode  out  2  current state: 0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC.
REQ-010 tick  out  1  one-cycle pulse at each 1 s prescaler terminal count.

Function
REQ-011 Press detect: press = btn AND NOT btn registered one cycle earlier; exactly one cycle per rising edge; a held button yields one press.
REQ-012 Prescaler counts 0..CLK_HZ-1, wraps to 0; tick asserted in the cycle count = CLK_HZ-1; it runs in all states.
REQ-013 FSM: RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN, one step per mode press; no other transitions.
REQ-014 RUN: on tick, sec_u increments BCD; carry chain sec_u 9->0 to sec_t, sec_t 5->0 to min_u, min_u 9->0 to min_t, min_t 5->0 to hours; 23:59:59 -> 00:00:00 in one tick.
REQ-015 Hours held as hr_t (0..2) and hr_u (0..9); hr_u wraps 9->0 with carry, except 23 wraps to 00.
REQ-016 SET_x states: tick ignored for timekeeping; inc press increments selected field only, no carry: hours 23->00, minutes 59->00, seconds 59->00.
REQ-017 Mode and inc press in same cycle: mode wins, inc discarded.
REQ-018 Transition SET_SEC -> RUN clears prescaler to 0; first RUN tick follows exactly CLK_HZ cycles later.
REQ-019 Scan counter 0..SCAN_DIV-1; at terminal count digit index advances 0..5, 5 wraps to 0.
REQ-020 Digit map: index 0 sec_u, 1 sec_t, 2 min_u, 3 min_t, 4 hr_u, 5 hr_t; an[index] low; an[7:6] always high.
REQ-021 Blink: in SET_x states, the selected field's two digits show ca = 8'hFF while prescaler >= CLK_HZ/2.
REQ-022 Segment codes 0..9: 03,9F,25,0D,99,49,C1,1F,01,19 (hex); 10..15 decode to FF.
REQ-023 an and ca registered; they change one cycle after the digit index changes and are never glitched between slots.
REQ-024 mode output reflects FSM state register directly, zero latency.

Reset
REQ-025 rst asserted: time 00:00:00, state RUN, prescaler 0, scan counter 0, digit index 0, btn registers 0, tick 0, an = 8'hFF, ca = 8'hFF.
REQ-026 rst mid-SET or mid-carry aborts the operation; no partial update survives; first tick after release at CLK_HZ cycles.
REQ-027 Button held across rst release produces no press.

Structure
REQ-028 Shared package clk_pkg holds FSM state encoding, SEG_BLANK = 8'hFF, NUM_DIGITS = 6, and field limit constants.
REQ-029 One sub-module, seg7_decode: combinational 4-bit BCD to 8-bit active-low segments per REQ-022.

Verification (CLK_HZ=10, SCAN_DIV=4)
REQ-030 Reset, run 10 cycles -> tick once, sec_u = 1, an cycles FE,FD,FB,F7,EF,DF every 4 cycles.
REQ-031 Preload 23:59:59 via set mode, return to RUN, wait 10 cycles -> 00:00:00, all digits show ca = 03.
REQ-032 SET_MIN, 61 inc presses from 00 -> minutes = 01, hours and seconds unchanged, no tick advance.
REQ-033 Mode and inc pressed same cycle in RUN -> mode = 1, hours unchanged.
REQ-034 Hold btn_inc 50 cycles in SET_HR -> hours +1 only.
REQ-035 rst pulse during SET_SEC at 12:34:56 -> mode = 0, time 00:00:00, an = FF, ca = FF next cycle.
